// File: rtl/led_flow_monitor.sv
// led_flow_monitor: passive checker for the flow-LED blinker bus.
// Measures change-to-change intervals on led_in and checks both the 01/10
// alternation and the interval window. Reports lock and a sticky first-error code.
// Optional macro LED_MON_TIMEOUT_EN enables stuck-bus detection (err_code 11).
module led_flow_monitor #(
    parameter int unsigned EXP_PERIOD = 25_000_000,
    parameter int unsigned TOL        = 1000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [1:0]       led_in,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] period,
    output logic [15:0]      edge_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    localparam logic [1:0] EC_NONE    = 2'b00;
    localparam logic [1:0] EC_ILLEGAL = 2'b01;
    localparam logic [1:0] EC_PERIOD  = 2'b10;
    localparam logic [1:0] EC_STUCK   = 2'b11;

    // Window bounds carry one extra bit so a saturated cnt+1 cannot wrap into range.
    localparam logic [CNT_W:0] WIN_LO = (CNT_W+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(EXP_PERIOD + TOL);

    logic [1:0]       led_m_q, led_s_q, led_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [15:0]      edge_cnt_q, edge_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic             change_c, pattern_ok_c, legal_c, in_win_c, stuck_c;
    logic [CNT_W:0]   interval_c;

    // Two-flop synchronizer plus previous-sample register; untouched by clr.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_m_q <= 2'b00;
            led_s_q <= 2'b00;
            led_q   <= 2'b00;
        end else begin
            led_m_q <= led_in;
            led_s_q <= led_m_q;
            led_q   <= led_s_q;
        end
    end

    // Change detection, legality, window and stuck conditions.
    always_comb begin
        change_c     = (led_s_q != led_q);
        pattern_ok_c = (led_s_q == 2'b01) || (led_s_q == 2'b10);
        legal_c      = pattern_ok_c && (led_s_q == ~led_q);
        interval_c   = {1'b0, cnt_q} + (CNT_W+1)'(1);
        in_win_c     = (interval_c >= WIN_LO) && (interval_c <= WIN_HI);
`ifdef LED_MON_TIMEOUT_EN
        stuck_c      = !change_c && (interval_c > WIN_HI);
`else
        stuck_c      = 1'b0;
`endif
    end

    // Next-state, counters and status; clr overrides everything else.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        edge_cnt_d = edge_cnt_q;
        err_code_d = err_code_q;

        if (change_c) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (change_c && (state_q != ST_IDLE)) begin
            period_d = interval_c[CNT_W] ? '1 : interval_c[CNT_W-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (change_c && pattern_ok_c) begin
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ, ST_LOCKED: begin
                if (change_c) begin
                    if (legal_c && in_win_c) begin
                        state_d    = ST_LOCKED;
                        edge_cnt_d = edge_cnt_q + 16'd1;
                    end else begin
                        state_d    = ST_ERROR;
                        err_code_d = legal_c ? EC_PERIOD : EC_ILLEGAL;
                    end
                end else if (stuck_c) begin
                    state_d    = ST_ERROR;
                    err_code_d = EC_STUCK;
                end
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase

        if (clr) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            period_d   = '0;
            edge_cnt_d = '0;
            err_code_d = EC_NONE;
        end

        locked_d = (state_d == ST_LOCKED);
        err_d    = (state_d == ST_ERROR);
    end

    // State and status registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            edge_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= EC_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            edge_cnt_q <= edge_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign period   = period_q;
    assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_led_flow_monitor.sv
// Bench for led_flow_monitor with EXP_PERIOD=100, TOL=2.
// Expected status is queued when an LED change is driven and popped three
// clocks later, when the monitor's registered outputs reflect that change.
module tb_led_flow_monitor;

    localparam int unsigned EXP   = 100;
    localparam int unsigned TOL   = 2;
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic             locked;
        logic             err;
        logic [1:0]       code;
        logic [CNT_W-1:0] period;
        logic [15:0]      edges;
    } st_t;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             clr;
    logic [1:0]       led_in;
    logic             locked;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] period;
    logic [15:0]      edge_cnt;

    st_t sb[$];
    st_t got, want;
    int  total = 0;
    int  bad   = 0;

    led_flow_monitor #(
        .EXP_PERIOD(EXP),
        .TOL       (TOL),
        .CNT_W     (CNT_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .led_in  (led_in),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .err_code(err_code),
        .period  (period),
        .edge_cnt(edge_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic st_t mk(input logic l, input logic e, input logic [1:0] c,
                               input int unsigned p, input int unsigned n);
        st_t s;
        s.locked = l;
        s.err    = e;
        s.code   = c;
        s.period = CNT_W'(p);
        s.edges  = 16'(n);
        return s;
    endfunction

    function automatic st_t observe();
        st_t s;
        s.locked = locked;
        s.err    = err;
        s.code   = err_code;
        s.period = period;
        s.edges  = edge_cnt;
        return s;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Drive a new LED value `gap` clocks after the previous drive and queue its expected result.
    task automatic change_after(input int gap, input logic [1:0] v, input st_t e);
        hold(gap - 3);
        led_in = v;
        sb.push_back(e);
        hold(3);
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        sb.push_back(mk(0, 0, 2'b00, 0, 0));
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        clr     = 1'b0;
        led_in  = 2'b00;
        sb.push_back(mk(0, 0, 2'b00, 0, 0));
        hold(3);
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL reset_held: got %p want %p", got, want); end
        sys_rst = 1'b0;
        sb.push_back(mk(0, 0, 2'b00, 0, 0));
        hold(2);
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL reset_released: got %p want %p", got, want); end
    endtask

    task automatic test_lock();
        change_after(10, 2'b01, mk(0, 0, 2'b00, 0, 0));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL lock_first: got %p want %p", got, want); end
        for (int i = 1; i <= 4; i++) begin
            change_after(100, (i % 2 == 1) ? 2'b10 : 2'b01, mk(1, 0, 2'b00, 100, i));
            got = observe(); want = sb.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL lock_step%0d: got %p want %p", i, got, want); end
        end
    endtask

    task automatic test_window_pass();
        change_after(98, 2'b10, mk(1, 0, 2'b00, 98, 5));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL win_low_edge: got %p want %p", got, want); end
        change_after(102, 2'b01, mk(1, 0, 2'b00, 102, 6));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL win_high_edge: got %p want %p", got, want); end
    endtask

    task automatic test_period_err();
        change_after(97, 2'b10, mk(0, 1, 2'b10, 97, 6));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL period_short: got %p want %p", got, want); end
    endtask

    task automatic test_clr();
        change_after(100, 2'b01, mk(0, 1, 2'b10, 100, 6));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL err_hold: got %p want %p", got, want); end
        // clr lands exactly in the detection cycle of a legal change.
        hold(97);
        led_in = 2'b10;
        hold(2);
        clear_pulse();
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL clr_with_change: got %p want %p", got, want); end
        change_after(100, 2'b01, mk(0, 0, 2'b00, 0, 0));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL clr_reacq: got %p want %p", got, want); end
        change_after(100, 2'b10, mk(1, 0, 2'b00, 100, 1));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL clr_relock: got %p want %p", got, want); end
    endtask

    task automatic test_illegal();
        change_after(100, 2'b11, mk(0, 1, 2'b01, 100, 1));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL illegal_pat: got %p want %p", got, want); end
        change_after(50, 2'b10, mk(0, 1, 2'b01, 50, 1));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL illegal_sticky: got %p want %p", got, want); end
        clear_pulse();
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL illegal_clr: got %p want %p", got, want); end
        change_after(10, 2'b01, mk(0, 0, 2'b00, 0, 0));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL illegal_reacq: got %p want %p", got, want); end
        change_after(100, 2'b10, mk(1, 0, 2'b00, 100, 1));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL illegal_relock: got %p want %p", got, want); end
    endtask

    task automatic test_window_hi();
        change_after(103, 2'b01, mk(0, 1, 2'b10, 103, 1));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL period_long: got %p want %p", got, want); end
        clear_pulse();
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL long_clr: got %p want %p", got, want); end
        change_after(10, 2'b10, mk(0, 0, 2'b00, 0, 0));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL long_reacq: got %p want %p", got, want); end
        change_after(100, 2'b01, mk(1, 0, 2'b00, 100, 1));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL long_relock: got %p want %p", got, want); end
    endtask

    task automatic test_timeout();
        // cnt reaches 102 in the cycle ending 106 clocks after the last drive.
        hold(102);
        sb.push_back(mk(1, 0, 2'b00, 100, 1));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL stuck_before: got %p want %p", got, want); end
        hold(1);
`ifdef LED_MON_TIMEOUT_EN
        sb.push_back(mk(0, 1, 2'b11, 100, 1));
`else
        sb.push_back(mk(1, 0, 2'b00, 100, 1));
`endif
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL stuck_fire: got %p want %p", got, want); end
        hold(94);
        led_in = 2'b10;
`ifdef LED_MON_TIMEOUT_EN
        sb.push_back(mk(0, 1, 2'b11, 200, 1));
`else
        sb.push_back(mk(0, 1, 2'b10, 200, 1));
`endif
        hold(3);
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL stuck_late_change: got %p want %p", got, want); end
        clear_pulse();
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL stuck_clr: got %p want %p", got, want); end
        change_after(10, 2'b01, mk(0, 0, 2'b00, 0, 0));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL stuck_reacq: got %p want %p", got, want); end
        change_after(100, 2'b10, mk(1, 0, 2'b00, 100, 1));
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL stuck_relock: got %p want %p", got, want); end
    endtask

    task automatic test_async_reset();
        // Assert reset between clock edges and look before the next posedge.
        #2;
        sys_rst = 1'b1;
        sb.push_back(mk(0, 0, 2'b00, 0, 0));
        #1;
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL async_reset: got %p want %p", got, want); end
        hold(3);
        sys_rst = 1'b0;
        sb.push_back(mk(0, 0, 2'b00, 0, 0));
        hold(4);
        got = observe(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL after_async_reset: got %p want %p", got, want); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_window_pass();
        test_period_err();
        test_clr();
        test_illegal();
        test_window_hi();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_flow_monitor.md
# led_flow_monitor

Passive checker on the 2-bit LED bus produced by the flow-LED blinker. It measures the interval in `sys_clk` cycles between LED pattern changes and checks both the interval and the alternation sequence. It reports a lock indication and a sticky error code. It sits beside the blinker in the top level as a built-in self-check for on-board bring-up and for the simulation bench.

## Interface
Parameters:
- `EXP_PERIOD`, default 25_000_000: expected cycles between LED changes (0.5 s at 50 MHz).
- `TOL`, default 1000: allowed ± deviation in cycles; must be less than `EXP_PERIOD`.
- `CNT_W`, default 32: width of the interval counter and `period`.

Ports:
- `sys_clk` in 1: system clock, 50 MHz nominal.
- `sys_rst` in 1: asynchronous active-high reset.
- `led_in` in 2: LED bus under test; asynchronous to `sys_clk`.
- `clr` in 1: synchronous clear; returns the block to IDLE and clears all status.
- `locked` out 1: high while the pattern is being tracked correctly.
- `err` out 1: sticky error flag.
- `err_code` out 2: first error type. 00 none, 01 illegal pattern, 10 period out of window, 11 stuck (timeout).
- `period` out CNT_W: last measured change-to-change interval.
- `edge_cnt` out 16: number of legal changes accepted; wraps from 0xFFFF to 0.

## Operation
- `led_in` passes through a 2-flop synchronizer to `led_s`. `led_q` holds the previous `led_s`. A change is `led_s != led_q`.
- A change is legal when `led_s` is 01 or 10 and `led_s == ~led_q`.
- Interval counter `cnt`:
  - Cleared to 0 in the cycle a change is detected.
  - Otherwise increments by 1 and saturates at all-ones.
  - The measured interval is `cnt+1`.
- Window check: `EXP_PERIOD-TOL <= cnt+1 <= EXP_PERIOD+TOL`.
- States:
  - IDLE: waits for the first change to 01 or 10, then goes to ACQ with `cnt` = 0. Other changes are ignored. No timeout in IDLE.
  - ACQ: on a change, `period` <= `cnt+1`. If the change is legal and in the window, go to LOCKED and increment `edge_cnt`. Otherwise go to ERROR.
  - LOCKED: `locked`=1. Each change updates `period` and is checked. A pass increments `edge_cnt`. A fail goes to ERROR.
  - ERROR: `err`=1, `locked`=0. `err_code` is latched on entry and later errors do not overwrite it. Changes are still counted into `period`, but the state holds until `clr`.
- Error priority when several conditions hold in one cycle: illegal pattern (01), then period (10), then timeout (11).
- Timeout: in ACQ or LOCKED, with no change when `cnt+1` exceeds `EXP_PERIOD+TOL`, go to ERROR with code 11.
- `clr` has priority over a change in the same cycle. It clears `cnt`, `period`, `edge_cnt`, `err`, `err_code` and `locked`, and enters IDLE. The synchronizer is not cleared.

## Timing
- Reset values: `locked`=0, `err`=0, `err_code`=00, `period`=0, `edge_cnt`=0, state IDLE, synchronizer flops 00.
- Latency: a `led_in` transition is seen on `led_s` after 2 clocks. The change is detected in the 3rd cycle. `locked`, `err`, `period` and `edge_cnt` update at the clock edge ending the detection cycle.
- The timeout fires in the cycle where `cnt` reaches `EXP_PERIOD+TOL`. Outputs reflect it one clock later.
- Saturation: `cnt` never wraps. A saturated interval fails the window check.
- Reset during operation: asynchronous return to the reset values regardless of state.

## Configuration
- Macro `LED_MON_TIMEOUT_EN`.
- Defined: stuck detection is active and `err_code` 11 is reachable.
- Undefined: no timeout logic. A stuck bus leaves the block in its current state until the next change, which is then window-checked. Code 11 is never produced.

## Test plan
Bench parameters: `EXP_PERIOD`=100, `TOL`=2, `LED_MON_TIMEOUT_EN` defined.
- Reset, then toggle 01↔10 every 100 cycles for 5 changes -> `locked`=1 after the 2nd change, `period`=100, `edge_cnt`=4, `err`=0.
- Locked, then the next change comes after 97 cycles -> `err`=1, `err_code`=10, `period`=97, `locked`=0.
- Locked, then `led_in` goes to 11 -> `err_code`=01. A following period error leaves the code at 01.
- Locked, then `led_in` is held for 200 cycles -> `err_code`=11 one clock after `cnt` reaches 102.
- In ERROR, assert `clr` in the same cycle as a legal change -> IDLE with all status 0 and `edge_cnt`=0. The next two good changes re-lock.
- Assert `sys_rst` mid-LOCKED, asynchronously -> all outputs go to reset values immediately, without waiting for a clock edge.
